// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Receives a big-endian byte stream, packs it into 32-bit words and
//            writes them into an instruction memory while holding the core
//            stalled. Each word is written at consecutive word addresses
//            starting at BaseAddr, wrapping modulo MemDepth. A receive-idle
//            timeout aborts the load without writing the partial word.
// Ports    : Clk, Rst_n           - clock, asynchronous active-low reset
//            Start, WordCount     - load request and word count (1..256)
//            ByteIn, ByteValid    - byte-stream source
//            ByteReady            - loader accepts a byte this cycle
//            MemWrEn/Addr/Data    - instruction-memory write port (byte addr)
//            stallDetector        - 0 holds the core, 1 lets it run
//            Busy, Done, Error    - status; Done/Error are one-cycle pulses
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int MemDepth = 256,
  parameter int BaseAddr = 0,
  parameter int Timeout  = 1024
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [8:0]  WordCount,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        MemWrEn,
  output logic [31:0] MemWrAddr,
  output logic [31:0] MemWrData,
  output logic        stallDetector,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam int IDX_W  = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam int IDLE_W = $clog2(Timeout + 1);

  localparam logic [IDX_W-1:0]  INIT_IDX   = IDX_W'((BaseAddr / 4) % MemDepth);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(MemDepth - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(Timeout - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t              state;
  logic [8:0]          count;      // words still to be written
  logic [IDX_W-1:0]    word_idx;   // word index of the next write
  logic [1:0]          byte_cnt;   // bytes accepted for the current word
  logic [IDLE_W-1:0]   idle_cnt;   // idle cycles since last byte / RECV entry
  logic [23:0]         shift;      // first three bytes of the current word

  wire byte_take = ByteValid && ByteReady;
  wire start_ok  = Start && (WordCount != 9'd0) && (WordCount <= 9'd256);

  // All outputs are registered and updated together with the state so that
  // they change only on the clock edge that enters the matching state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      count         <= '0;
      word_idx      <= '0;
      byte_cnt      <= '0;
      idle_cnt      <= '0;
      shift         <= '0;
      ByteReady     <= 1'b0;
      MemWrEn       <= 1'b0;
      MemWrAddr     <= '0;
      MemWrData     <= '0;
      stallDetector <= 1'b1;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Error         <= 1'b0;
    end else begin
      // Pulse outputs default low; only the entering transition raises them.
      MemWrEn <= 1'b0;
      Done    <= 1'b0;
      Error   <= 1'b0;

      case (state)
        IDLE: begin
          if (start_ok) begin
            state         <= RECV;
            count         <= WordCount;
            word_idx      <= INIT_IDX;
            byte_cnt      <= '0;
            idle_cnt      <= '0;
            ByteReady     <= 1'b1;
            stallDetector <= 1'b0;
            Busy          <= 1'b1;
          end
        end

        RECV: begin
          if (byte_take) begin
            idle_cnt <= '0;
            shift    <= {shift[15:0], ByteIn};
            if (byte_cnt == 2'd3) begin
              // Fourth byte goes straight into the write data register.
              state     <= WRITE;
              byte_cnt  <= '0;
              ByteReady <= 1'b0;
              MemWrEn   <= 1'b1;
              MemWrAddr <= 32'({word_idx, 2'b00});
              MemWrData <= {shift, ByteIn};
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else if (idle_cnt == IDLE_LIMIT) begin
            // Abort: the partially assembled word is simply dropped.
            state     <= ERR;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            ByteReady <= 1'b0;
            Error     <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end

        WRITE: begin
          word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + IDX_W'(1);
          count    <= count - 9'd1;
          if (count == 9'd1) begin
            state <= DONE;
            Done  <= 1'b1;
          end else begin
            state     <= RECV;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            ByteReady <= 1'b1;
          end
        end

        DONE, ERR: begin
          state         <= IDLE;
          stallDetector <= 1'b1;
          Busy          <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          ByteReady     <= 1'b0;
          stallDetector <= 1'b1;
          Busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Scoreboard bench for imem_loader. Two instances share stimulus:
//            dut0 uses BaseAddr 0, dut1 uses BaseAddr 0x3FC (wraps to 0 on the
//            second word). Expected writes are queued per instance when the
//            stimulus is issued and popped by negedge monitors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Start;
  logic [8:0] WordCount;
  logic [7:0] ByteIn;
  logic       ByteValid;

  logic        br0, we0, st0, busy0, done0, err0;
  logic [31:0] wa0, wd0;
  logic        br1, we1, st1, busy1, done1, err1;
  logic [31:0] wa1, wd1;

  always #5 Clk = ~Clk;

  imem_loader #(.MemDepth(256), .BaseAddr(0), .Timeout(16)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .WordCount(WordCount),
    .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(br0),
    .MemWrEn(we0), .MemWrAddr(wa0), .MemWrData(wd0),
    .stallDetector(st0), .Busy(busy0), .Done(done0), .Error(err0)
  );

  imem_loader #(.MemDepth(256), .BaseAddr(32'h3FC), .Timeout(16)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .WordCount(WordCount),
    .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(br1),
    .MemWrEn(we1), .MemWrAddr(wa1), .MemWrData(wd1),
    .stallDetector(st1), .Busy(busy1), .Done(done1), .Error(err1)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];

  int vectors     = 0;
  int miscompares = 0;
  int wr_cnt0 = 0, done_cnt0 = 0, err_cnt0 = 0;
  int wr_cnt1 = 0, done_cnt1 = 0, err_cnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d);
    q0.push_back('{a: a0, d: d});
    q1.push_back('{a: a1, d: d});
  endtask

  // Monitors: pop and compare on every write strobe.
  always @(negedge Clk) begin
    wr_t e;
    if (we0 === 1'b1) begin
      wr_cnt0++;
      if (q0.size() == 0) begin
        chk("dut0 unexpected write addr", wa0, 32'hFFFF_FFFF);
      end else begin
        e = q0.pop_front();
        chk("dut0 write addr", wa0, e.a);
        chk("dut0 write data", wd0, e.d);
      end
    end
    if (done0 === 1'b1) done_cnt0++;
    if (err0 === 1'b1) err_cnt0++;
    chk("dut0 stall vs busy", {31'd0, st0}, {31'd0, ~busy0});
  end

  always @(negedge Clk) begin
    wr_t e;
    if (we1 === 1'b1) begin
      wr_cnt1++;
      if (q1.size() == 0) begin
        chk("dut1 unexpected write addr", wa1, 32'hFFFF_FFFF);
      end else begin
        e = q1.pop_front();
        chk("dut1 write addr", wa1, e.a);
        chk("dut1 write data", wd1, e.d);
      end
    end
    if (done1 === 1'b1) done_cnt1++;
    if (err1 === 1'b1) err_cnt1++;
  end

  // All tasks are entered and left 1 ns after a rising edge.
  task automatic do_start(input logic [8:0] wc);
    Start     = 1'b1;
    WordCount = wc;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n         = 0;
    ByteIn    = b;
    ByteValid = 1'b1;
    forever begin
      @(negedge Clk);
      if (br0 === 1'b1) break;
      n++;
      if (n > 50) begin
        chk("send_byte ready timeout", {31'd0, br0}, 32'd1);
        break;
      end
    end
    @(posedge Clk); #1;
    ByteValid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy0 !== 1'b0 && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk(name, {31'd0, busy0}, 32'd0);
    chk({name, " stall"}, {31'd0, st0}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " ByteReady"}, {31'd0, br0}, 32'd0);
    chk({name, " MemWrEn"},   {31'd0, we0}, 32'd0);
    chk({name, " MemWrAddr"}, wa0, 32'd0);
    chk({name, " MemWrData"}, wd0, 32'd0);
    chk({name, " Busy"},      {31'd0, busy0}, 32'd0);
    chk({name, " Done"},      {31'd0, done0}, 32'd0);
    chk({name, " Error"},     {31'd0, err0}, 32'd0);
    chk({name, " stall"},     {31'd0, st0}, 32'd1);
    chk({name, " dut1 MemWrAddr"}, wa1, 32'd0);
  endtask

  logic [7:0] t1 [8] = '{8'h8E, 8'h71, 8'h00, 8'h14, 8'h8E, 8'h28, 8'h00, 8'h00};

  initial begin
    int w0, d0, e0, w1, d1, n;

    Rst_n = 1'b0; Start = 1'b0; WordCount = '0; ByteIn = '0; ByteValid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk_reset_outputs("reset");
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Two-word back-to-back load; dut1 wraps 0x3FC -> 0x000.
    w0 = wr_cnt0; d0 = done_cnt0; e0 = err_cnt0; w1 = wr_cnt1; d1 = done_cnt1;
    chk("idle stall", {31'd0, st0}, 32'd1);
    push_exp(32'h0000_0000, 32'h0000_03FC, 32'h8E71_0014);
    push_exp(32'h0000_0004, 32'h0000_0000, 32'h8E28_0000);
    do_start(9'd2);
    chk("busy after start", {31'd0, busy0}, 32'd1);
    chk("stall after start", {31'd0, st0}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_byte(t1[i]);
      if (i == 3) begin
        chk("write strobe latency", {31'd0, we0}, 32'd1);
        chk("ready low in write", {31'd0, br0}, 32'd0);
      end
    end
    wait_idle("load2 idle");
    chk("load2 writes", wr_cnt0 - w0, 32'd2);
    chk("load2 done pulses", done_cnt0 - d0, 32'd1);
    chk("load2 error pulses", err_cnt0 - e0, 32'd0);
    chk("load2 dut1 writes", wr_cnt1 - w1, 32'd2);
    chk("load2 dut1 done pulses", done_cnt1 - d1, 32'd1);

    // Gapped source; stray bytes offered in IDLE must be ignored.
    w0 = wr_cnt0; d0 = done_cnt0;
    ByteIn = 8'hAA; ByteValid = 1'b1;
    repeat (3) @(posedge Clk);
    #1 ByteValid = 1'b0;
    push_exp(32'h0000_0000, 32'h0000_03FC, 32'hDEAD_BEEF);
    do_start(9'd1);
    send_byte(8'hDE);
    ByteIn = 8'h55; repeat (3) @(posedge Clk); #1;
    send_byte(8'hAD);
    ByteIn = 8'h55; repeat (3) @(posedge Clk); #1;
    send_byte(8'hBE);
    ByteIn = 8'h55; repeat (3) @(posedge Clk); #1;
    send_byte(8'hEF);
    wait_idle("gapped idle");
    chk("gapped writes", wr_cnt0 - w0, 32'd1);
    chk("gapped done pulses", done_cnt0 - d0, 32'd1);

    // Timeout: two bytes then silence.
    w0 = wr_cnt0; d0 = done_cnt0; e0 = err_cnt0;
    do_start(9'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    n = 0;
    while (err0 !== 1'b1 && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("timeout cycles", n, 32'd16);
    wait_idle("timeout idle");
    chk("timeout writes", wr_cnt0 - w0, 32'd0);
    chk("timeout error pulses", err_cnt0 - e0, 32'd1);
    chk("timeout done pulses", done_cnt0 - d0, 32'd0);

    // Reset after 6 bytes of a 3-word load.
    w0 = wr_cnt0; d0 = done_cnt0; e0 = err_cnt0;
    push_exp(32'h0000_0000, 32'h0000_03FC, 32'h0102_0304);
    do_start(9'd3);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    Rst_n = 1'b0;
    #1;
    chk_reset_outputs("midload reset");
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    chk("midload writes", wr_cnt0 - w0, 32'd1);
    chk("midload done pulses", done_cnt0 - d0, 32'd0);
    chk("midload error pulses", err_cnt0 - e0, 32'd0);
    chk("midload busy", {31'd0, busy0}, 32'd0);

    // Ignored starts: count 0, count 300, and Start during RECV.
    w0 = wr_cnt0; d0 = done_cnt0;
    do_start(9'd0);
    chk("start wc0 ignored", {31'd0, busy0}, 32'd0);
    do_start(9'd300);
    chk("start wc300 ignored", {31'd0, busy0}, 32'd0);
    push_exp(32'h0000_0000, 32'h0000_03FC, 32'hCAFE_F00D);
    do_start(9'd1);
    send_byte(8'hCA);
    send_byte(8'hFE);
    do_start(9'd5);
    send_byte(8'hF0);
    send_byte(8'h0D);
    wait_idle("restart idle");
    chk("restart writes", wr_cnt0 - w0, 32'd1);
    chk("restart done pulses", done_cnt0 - d0, 32'd1);

    repeat (5) @(posedge Clk);
    #1;
    chk("dut0 queue drained", q0.size(), 32'd0);
    chk("dut1 queue drained", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
